fetch_pc_gen: RTL and testbench
===============================

Name: fetch_pc_gen

Overview:
Fetch-stage next-PC generator that sits directly upstream of the direction predictor. It holds the fetch PC and drives that PC as the predictor's read address. It combines the predictor's same-cycle direction bit with a direct-mapped branch target buffer (BTB) to choose the next PC. It detects mispredictions from execute-stage resolution, redirects fetch, and emits the registered branch-update bus that trains the predictor's counter table.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
BTB_IDX_BITS, 6, log2 of BTB entry count (64 entries)
TAG_BITS, 30-BTB_IDX_BITS, BTB tag width, taken from pc[31:BTB_IDX_BITS+2]

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
stall_i  in  1  hold PC (decode/IF backpressure)
pc_o  out  32  current fetch PC; also the predictor read address
fetch_valid_o  out  1  pc_o is a valid, non-killed fetch this cycle
prediction_i  in  1  predictor direction for pc_o, same cycle (combinational)
pred_taken_o  out  1  BTB hit AND prediction_i; travels down the pipe with the instruction
pred_target_o  out  32  BTB target for pc_o ({target,2'b00}); 0 on miss
res_valid_i  in  1  a conditional branch or jump resolves in EX this cycle
res_pc_i  in  32  PC of the resolving branch
res_taken_i  in  1  actual direction
res_target_i  in  32  actual target
res_pred_taken_i  in  1  pred_taken_o value that travelled with this branch
res_pred_target_i  in  32  pred_target_o value that travelled with this branch
mispredict_o  out  1  combinational flush request to IF/ID
upd_o  out  core::br_cntrl_bus_t  registered update: i_addr, is_taken
upd_valid_o  out  1  registered; drives the predictor's is_branch_i

Behaviour:
- Reset (rst=1 at a posedge):
  - pc_q <= RESET_PC; all BTB valid bits <= 0.
  - fetch_valid_q <= 0; upd_valid_o <= 0; upd_o <= '0.
  - Tag and target arrays are not reset.
- fetch_valid_q is set to 1 on the first non-reset posedge and stays 1.
- fetch_valid_o = fetch_valid_q & ~mispredict_o.
- BTB lookup is combinational on pc_q:
  - index = pc[BTB_IDX_BITS+1:2]
  - hit = valid[index] && tag[index]==pc[31:BTB_IDX_BITS+2]
- pred_taken_o = hit & prediction_i & fetch_valid_q.
- mispredict_o = res_valid_i & ((res_taken_i != res_pred_taken_i) | (res_taken_i & (res_target_i != res_pred_target_i))).
- Correct PC = res_taken_i ? {res_target_i[31:2],2'b00} : res_pc_i+4.
- Next-PC priority, evaluated at each posedge:
  1. rst -> RESET_PC
  2. mispredict_o -> correct PC; the redirect overrides stall_i
  3. stall_i -> hold pc_q
  4. pred_taken_o -> pred_target_o
  5. otherwise pc_q+4, wrapping modulo 2^32
- BTB write when res_valid_i & res_taken_i, at the posedge:
  - valid[ridx] <= 1; tag[ridx] <= res_pc tag; target[ridx] <= res_target_i[31:2]
  - ridx is the index derived from res_pc_i.
  - A not-taken resolution leaves the BTB unchanged; direction is the counter's job.
- BTB write and read at the same index in the same cycle: the read returns the old contents; the new entry is visible the next cycle.
- A BTB write with a different tag at an occupied index overwrites the entry (aliasing eviction).
- Update bus, one-cycle latency: on every res_valid_i, next cycle upd_valid_o=1, upd_o.i_addr=res_pc_i, upd_o.is_taken=res_taken_i. Otherwise upd_valid_o=0.
- Update bus is independent of stall_i.
- A reset asserted mid-redirect discards the redirect and any pending update.
- pc_o and all targets are word-aligned; bits [1:0] are forced to 0.

Decomposition:
- Add to package core:
  - btb_entry_t {valid, tag[TAG_BITS], target[29:0]}
  - BTB_IDX_BITS and RESET_PC defaults
- Reuse br_cntrl_bus_t from core.
- One natural sub-module: btb_dm, holding the direct-mapped arrays, combinational read, synchronous write and synchronous valid clear.
- Next-PC mux and mispredict compare stay in fetch_pc_gen.

Test Plan:
1. Reset: hold rst=1 for 3 cycles, then release -> pc_o=0 and fetch_valid_o=0 during reset; fetch_valid_o=1 next cycle; pc_o steps 0,4,8,C; pred_taken_o=0.
2. Stall: stall_i=1 for 2 cycles at pc 0x10 -> pc_o holds 0x10, then 0x14 after release.
3. Train and predict:
   - Resolve pc=0x20, taken, target=0x100, pred_taken=0 -> mispredict_o=1; next pc_o=0x100; upd_valid_o=1, i_addr=0x20, is_taken=1 one cycle later.
   - Later fetch of 0x20 with prediction_i=1 -> pred_taken_o=1, pred_target_o=0x100; next pc_o=0x100.
4. Wrong direction: resolve pc=0x20, taken=0, pred_taken=1 -> mispredict_o=1, fetch_valid_o=0 that cycle; next pc_o=0x24; BTB entry still valid.
5. Redirect versus stall: stall_i=1 in the same cycle as a mispredict to 0x200 -> pc_o=0x200 next cycle.
6. Aliasing: train 0x20 -> 0x100, then 0x120 -> 0x300 (same index) -> fetch 0x20 misses (pred_target_o=0); fetch 0x120 hits with target 0x300; PC wrap 0xFFFF_FFFC -> 0x0.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// Shared core types: the predictor update bus and the BTB entry layout,
// plus the defaults used by the fetch next-PC generator.
package core;

    localparam int          DEFAULT_BTB_IDX_BITS = 6;
    localparam int          DEFAULT_TAG_BITS     = 30 - DEFAULT_BTB_IDX_BITS;
    localparam logic [31:0] DEFAULT_RESET_PC     = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] i_addr;
        logic        is_taken;
    } br_cntrl_bus_t;

    typedef struct packed {
        logic                        valid;
        logic [DEFAULT_TAG_BITS-1:0] tag;
        logic [29:0]                 target;
    } btb_entry_t;

endpackage

// File: rtl/fetch_pc_gen_btb_dm.sv
// Direct-mapped branch target buffer: combinational read, synchronous write,
// and a synchronous clear of the valid bits only.
module btb_dm
    import core::*;
#(
    parameter int IDX_BITS = DEFAULT_BTB_IDX_BITS,
    parameter int TAG_BITS = 30 - IDX_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    input  logic [TAG_BITS-1:0] rd_tag_i,
    output logic                rd_hit_o,
    output logic [29:0]         rd_target_o,
    input  logic                wr_en_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0] wr_tag_i,
    input  logic [29:0]         wr_target_i
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [29:0]         target_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag/target storage is left unreset; a cleared valid bit masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
        end
    end

    assign rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_target_o = target_q[rd_idx_i];

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: BTB + same-cycle direction prediction,
// execute-stage mispredict redirect, and the registered predictor update bus.
module fetch_pc_gen
    import core::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int          BTB_IDX_BITS = DEFAULT_BTB_IDX_BITS,
    parameter int          TAG_BITS     = 30 - BTB_IDX_BITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    output logic [31:0]   pc_o,
    output logic          fetch_valid_o,
    input  logic          prediction_i,
    output logic          pred_taken_o,
    output logic [31:0]   pred_target_o,
    input  logic          res_valid_i,
    input  logic [31:0]   res_pc_i,
    input  logic          res_taken_i,
    input  logic [31:0]   res_target_i,
    input  logic          res_pred_taken_i,
    input  logic [31:0]   res_pred_target_i,
    output logic          mispredict_o,
    output br_cntrl_bus_t upd_o,
    output logic          upd_valid_o
);

    logic [31:0]   pc_q, pc_d;
    logic          fetch_valid_q;
    br_cntrl_bus_t upd_q, upd_d;
    logic          upd_valid_q;

    logic          btbHit;
    logic [29:0]   btbTarget;
    logic [31:0]   correctPc;
    logic          btbWrite;

    assign btbWrite = res_valid_i & res_taken_i;

    btb_dm #(
        .IDX_BITS (BTB_IDX_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (pc_q[BTB_IDX_BITS+1:2]),
        .rd_tag_i    (pc_q[31:BTB_IDX_BITS+2]),
        .rd_hit_o    (btbHit),
        .rd_target_o (btbTarget),
        .wr_en_i     (btbWrite),
        .wr_idx_i    (res_pc_i[BTB_IDX_BITS+1:2]),
        .wr_tag_i    (res_pc_i[31:BTB_IDX_BITS+2]),
        .wr_target_i (res_target_i[31:2])
    );

    assign pred_target_o = btbHit ? {btbTarget, 2'b00} : 32'h0;
    assign pred_taken_o  = btbHit & prediction_i & fetch_valid_q;

    // A target mismatch only matters when the branch was actually taken.
    assign mispredict_o  = res_valid_i &
                           ((res_taken_i != res_pred_taken_i) |
                            (res_taken_i & (res_target_i != res_pred_target_i)));

    assign correctPc     = res_taken_i ? {res_target_i[31:2], 2'b00} : (res_pc_i + 32'd4);

    assign fetch_valid_o = fetch_valid_q & ~mispredict_o;
    assign pc_o          = pc_q;
    assign upd_o         = upd_q;
    assign upd_valid_o   = upd_valid_q;

    // Redirect beats stall, stall beats the predicted target.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (mispredict_o) begin
            pc_d = correctPc;
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (pred_taken_o) begin
            pc_d = pred_target_o;
        end
        pc_d[1:0] = 2'b00;
    end

    always_comb begin
        upd_d = upd_q;
        if (res_valid_i) begin
            upd_d.i_addr   = res_pc_i;
            upd_d.is_taken = res_taken_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= {RESET_PC[31:2], 2'b00};
            fetch_valid_q <= 1'b0;
            upd_q         <= '0;
            upd_valid_q   <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            fetch_valid_q <= 1'b1;
            upd_q         <= upd_d;
            upd_valid_q   <= res_valid_i;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: a behavioural model queues the expected
// next PC and update-bus beat each cycle and pops them when the DUT presents them.
module tb_fetch_pc_gen;
    import core::*;

    logic          clk;
    logic          rst;
    logic          stall_i;
    logic [31:0]   pc_o;
    logic          fetch_valid_o;
    logic          prediction_i;
    logic          pred_taken_o;
    logic [31:0]   pred_target_o;
    logic          res_valid_i;
    logic [31:0]   res_pc_i;
    logic          res_taken_i;
    logic [31:0]   res_target_i;
    logic          res_pred_taken_i;
    logic [31:0]   res_pred_target_i;
    logic          mispredict_o;
    br_cntrl_bus_t upd_o;
    logic          upd_valid_o;

    fetch_pc_gen dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .pc_o              (pc_o),
        .fetch_valid_o     (fetch_valid_o),
        .prediction_i      (prediction_i),
        .pred_taken_o      (pred_taken_o),
        .pred_target_o     (pred_target_o),
        .res_valid_i       (res_valid_i),
        .res_pc_i          (res_pc_i),
        .res_taken_i       (res_taken_i),
        .res_target_i      (res_target_i),
        .res_pred_taken_i  (res_pred_taken_i),
        .res_pred_target_i (res_pred_target_i),
        .mispredict_o      (mispredict_o),
        .upd_o             (upd_o),
        .upd_valid_o       (upd_valid_o)
    );

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic        taken;
    } updExp_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] pcQ [$];
    updExp_t     updQ [$];

    logic        mFetchValid;
    logic        mValid [64];
    logic [23:0] mTag   [64];
    logic [29:0] mTgt   [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        stall_i           = 1'b0;
        prediction_i      = 1'b0;
        res_valid_i       = 1'b0;
        res_pc_i          = 32'h0;
        res_taken_i       = 1'b0;
        res_target_i      = 32'h0;
        res_pred_taken_i  = 1'b0;
        res_pred_target_i = 32'h0;
    endtask

    // Holds reset for n cycles; any resolution already on the inputs sees the first edge.
    task automatic doReset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            clearInputs();
            #1;
            checkOutput("rstPc", pc_o, 32'h0);
            checkOutput("rstFetchValid", {31'h0, fetch_valid_o}, 32'h0);
            checkOutput("rstUpdValid", {31'h0, upd_valid_o}, 32'h0);
            checkOutput("rstUpdAddr", upd_o.i_addr, 32'h0);
            checkOutput("rstPredTaken", {31'h0, pred_taken_o}, 32'h0);
        end
        for (int i = 0; i < 64; i++) mValid[i] = 1'b0;
        mFetchValid = 1'b0;
        pcQ.delete();
        updQ.delete();
        pcQ.push_back(32'h0);
        updQ.push_back('{valid: 1'b0, addr: 32'h0, taken: 1'b0});
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic stall, input logic pred,
                                 input logic rv, input logic [31:0] rpc, input logic rt,
                                 input logic [31:0] rtgt, input logic rpt, input logic [31:0] rptgt);
        logic [31:0] expPc, expTgt, nextPc, correct;
        logic        hit, expPredTaken, expMisp;
        logic [5:0]  idx;
        updExp_t     u;
        stall_i           = stall;
        prediction_i      = pred;
        res_valid_i       = rv;
        res_pc_i          = rpc;
        res_taken_i       = rt;
        res_target_i      = rtgt;
        res_pred_taken_i  = rpt;
        res_pred_target_i = rptgt;
        #1;
        checkOutput("pcQueueDepth", pcQ.size(), 32'd1);
        expPc = (pcQ.size() > 0) ? pcQ.pop_front() : 32'h0;
        checkOutput("pc", pc_o, expPc);

        idx          = expPc[7:2];
        hit          = mValid[idx] && (mTag[idx] == expPc[31:8]);
        expTgt       = hit ? {mTgt[idx], 2'b00} : 32'h0;
        expPredTaken = hit & pred & mFetchValid;
        expMisp      = rv & ((rt != rpt) | (rt & (rtgt != rptgt)));
        checkOutput("predTarget", pred_target_o, expTgt);
        checkOutput("predTaken", {31'h0, pred_taken_o}, {31'h0, expPredTaken});
        checkOutput("mispredict", {31'h0, mispredict_o}, {31'h0, expMisp});
        checkOutput("fetchValid", {31'h0, fetch_valid_o}, {31'h0, mFetchValid & ~expMisp});

        checkOutput("updQueueDepth", updQ.size(), 32'd1);
        if (updQ.size() > 0) begin
            u = updQ.pop_front();
            checkOutput("updValid", {31'h0, upd_valid_o}, {31'h0, u.valid});
            if (u.valid) begin
                checkOutput("updAddr", upd_o.i_addr, u.addr);
                checkOutput("updTaken", {31'h0, upd_o.is_taken}, {31'h0, u.taken});
            end
        end

        correct = rt ? {rtgt[31:2], 2'b00} : rpc + 32'd4;
        if (expMisp)           nextPc = correct;
        else if (stall)        nextPc = expPc;
        else if (expPredTaken) nextPc = expTgt;
        else                   nextPc = expPc + 32'd4;
        pcQ.push_back(nextPc);
        updQ.push_back('{valid: rv, addr: rpc, taken: rt});
        if (rv && rt) begin
            mValid[rpc[7:2]] = 1'b1;
            mTag[rpc[7:2]]   = rpc[31:8];
            mTgt[rpc[7:2]]   = rtgt[31:2];
        end
        mFetchValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic pred);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, pred, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Not-taken resolution predicted taken at addr-4 redirects fetch to addr without touching the BTB.
    task automatic jumpTo(input logic [31:0] addr);
        applyStimulus(1'b0, 1'b0, 1'b1, addr - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
    endtask

    task automatic train(input logic [31:0] bpc, input logic [31:0] tgt, input logic stall);
        applyStimulus(stall, 1'b0, 1'b1, bpc, 1'b1, tgt, 1'b0, 32'h0);
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        doReset(3);

        idle(4, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(2, 1'b0);

        train(32'h20, 32'h100, 1'b0);
        idle(2, 1'b1);
        jumpTo(32'h20);
        idle(3, 1'b1);

        jumpTo(32'h20);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 32'h100);
        idle(1, 1'b0);
        jumpTo(32'h20);
        idle(2, 1'b1);

        train(32'h40, 32'h200, 1'b1);
        idle(2, 1'b0);

        train(32'h120, 32'h300, 1'b0);
        jumpTo(32'h20);
        idle(1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h100, 1'b1, 32'h100);
        jumpTo(32'h120);
        idle(2, 1'b1);
        jumpTo(32'h120);
        idle(1, 1'b1);

        train(32'h0, 32'hFFFF_FFFC, 1'b0);
        idle(3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] rpc, rtgt, rptgt;
            logic        rt, rpt;
            rpc   = {22'h0, $urandom_range(0, 255), 2'b00};
            rtgt  = {22'h0, $urandom_range(0, 255), 2'($urandom_range(0, 3))};
            rt    = 1'($urandom_range(0, 1));
            rpt   = 1'($urandom_range(0, 1));
            rptgt = ($urandom_range(0, 1) == 1) ? rtgt : {22'h0, $urandom_range(0, 255), 2'b00};
            applyStimulus(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0), rpc, rt, rtgt, rpt, rptgt);
        end

        res_valid_i       = 1'b1;
        res_pc_i          = 32'h60;
        res_taken_i       = 1'b1;
        res_target_i      = 32'h400;
        res_pred_taken_i  = 1'b0;
        res_pred_target_i = 32'h0;
        doReset(2);
        idle(3, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
